// File: rtl/execute_stage_if.sv
// Execute-stage port bundle: ID/EX operands and controls in, registered EX/MEM outputs out.
// Handshake: an instruction is taken when in_valid is high and busy is low; while busy is high
// the stage ignores every in_* signal and the source must hold its instruction until busy drops.
interface execute_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic [XLEN-1:0] in_op1;
  logic [XLEN-1:0] in_op2;
  logic [XLEN-1:0] in_store_data;
  logic [4:0]      in_AluOp;
  logic            in_BranchEn;
  logic [2:0]      in_BranchCond;
  logic [11:0]     in_BranchOffset;
  logic            in_MemRead;
  logic            in_MemWrite;
  logic            in_MemToReg;
  logic            in_RegWrite;
  logic            in_RegDataSrc;
  logic [4:0]      in_RegDest;

  logic [XLEN-1:0] out_AluResult;
  logic [XLEN-1:0] out_StoreData;
  logic            out_MemRead;
  logic            out_MemWrite;
  logic            out_MemToReg;
  logic            out_RegWrite;
  logic            out_RegDataSrc;
  logic [4:0]      out_RegDest;
  logic            out_PCSrc;
  logic [11:0]     out_BranchOffset;
  logic            busy;
  logic [1:0]      dbgState;

  modport master (
    output in_valid, in_op1, in_op2, in_store_data, in_AluOp, in_BranchEn, in_BranchCond,
           in_BranchOffset, in_MemRead, in_MemWrite, in_MemToReg, in_RegWrite, in_RegDataSrc,
           in_RegDest,
    input  out_AluResult, out_StoreData, out_MemRead, out_MemWrite, out_MemToReg, out_RegWrite,
           out_RegDataSrc, out_RegDest, out_PCSrc, out_BranchOffset, busy, dbgState
  );

  modport slave (
    input  in_valid, in_op1, in_op2, in_store_data, in_AluOp, in_BranchEn, in_BranchCond,
           in_BranchOffset, in_MemRead, in_MemWrite, in_MemToReg, in_RegWrite, in_RegDataSrc,
           in_RegDest,
    output out_AluResult, out_StoreData, out_MemRead, out_MemWrite, out_MemToReg, out_RegWrite,
           out_RegDataSrc, out_RegDest, out_PCSrc, out_BranchOffset, busy, dbgState
  );
endinterface

// File: rtl/execute_stage.sv
// RV32 execute stage: ALU, branch resolution and the registered EX/MEM boundary.
// Define RV32M_EN to build the iterative multiply/divide unit (ops 11-18); otherwise those ops yield 0.
module execute_stage #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input logic       clk,
  input logic       rst,
  execute_stage_if.slave bus
);

  localparam logic [4:0] OpMul = 5'd11, OpMulh = 5'd12, OpMulhsu = 5'd13, OpMulhu = 5'd14;
  localparam logic [4:0] OpDiv = 5'd15, OpDivu = 5'd16, OpRem = 5'd17, OpRemu = 5'd18;

  typedef struct packed {
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic        regWrite;
    logic        regDataSrc;
    logic [4:0]  regDest;
    logic        pcSrc;
    logic [11:0] branchOffset;
  } ctrl_t;

  function automatic logic [XLEN-1:0] aluCalc(input logic [4:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    case (op)
      5'd0:    aluCalc = a + b;
      5'd1:    aluCalc = a - b;
      5'd2:    aluCalc = a << b[4:0];
      5'd3:    aluCalc = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      5'd4:    aluCalc = {{(XLEN-1){1'b0}}, a < b};
      5'd5:    aluCalc = a ^ b;
      5'd6:    aluCalc = a >> b[4:0];
      5'd7:    aluCalc = $signed(a) >>> b[4:0];
      5'd8:    aluCalc = a | b;
      5'd9:    aluCalc = a & b;
      5'd10:   aluCalc = b;
      default: aluCalc = '0;
    endcase
  endfunction

  function automatic logic branchTaken(input logic [2:0] cond, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    case (cond)
      3'b000:  branchTaken = (a == b);
      3'b001:  branchTaken = (a != b);
      3'b100:  branchTaken = ($signed(a) < $signed(b));
      3'b101:  branchTaken = ($signed(a) >= $signed(b));
      3'b110:  branchTaken = (a < b);
      3'b111:  branchTaken = (a >= b);
      default: branchTaken = 1'b0;
    endcase
  endfunction

  logic [XLEN-1:0] aluRes;
  ctrl_t           inCtrl;
  logic            isMdOp;
  logic            mdDone;
  logic            stateIdle;
  ctrl_t           ctrlL;
  logic [XLEN-1:0] storeL;
  logic [XLEN-1:0] mdResult;

  assign aluRes = aluCalc(bus.in_AluOp, bus.in_op1, bus.in_op2);
  assign inCtrl = {bus.in_MemRead, bus.in_MemWrite, bus.in_MemToReg, bus.in_RegWrite,
                   bus.in_RegDataSrc, bus.in_RegDest,
                   bus.in_valid & bus.in_BranchEn & branchTaken(bus.in_BranchCond, bus.in_op1, bus.in_op2),
                   bus.in_BranchOffset};

`ifdef RV32M_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LastIter = CW'(ITER - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            busyQ;
  logic [4:0]      opL;
  logic            negRes;
  logic [XLEN-1:0] accHi, accLo, magB, rawA;
  logic            signA, signB, isDivIn;
  logic [XLEN-1:0] magAIn, magBIn, nextHi, nextLo;
  logic [XLEN:0]   mulSum, divShift, divDiff;
  logic [2*XLEN-1:0] prod;

  assign isMdOp = (bus.in_AluOp >= OpMul) && (bus.in_AluOp <= OpRemu);

  // accHi:accLo is the product (mul) or remainder:quotient (div); magB is multiplicand or divisor.
  always_comb begin
    signA   = bus.in_op1[XLEN-1] & (bus.in_AluOp inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem});
    signB   = bus.in_op2[XLEN-1] & (bus.in_AluOp inside {OpMul, OpMulh, OpDiv, OpRem});
    isDivIn = (bus.in_AluOp >= OpDiv);
    magAIn  = signA ? -bus.in_op1 : bus.in_op1;
    magBIn  = signB ? -bus.in_op2 : bus.in_op2;

    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, magB} : {(XLEN+1){1'b0}});
    divShift = {accHi, accLo[XLEN-1]};
    divDiff  = divShift - {1'b0, magB};
    if (opL >= OpDiv) begin
      if (!divDiff[XLEN]) begin
        nextHi = divDiff[XLEN-1:0];
        nextLo = {accLo[XLEN-2:0], 1'b1};
      end else begin
        nextHi = divShift[XLEN-1:0];
        nextLo = {accLo[XLEN-2:0], 1'b0};
      end
    end else begin
      nextHi = mulSum[XLEN:1];
      nextLo = {mulSum[0], accLo[XLEN-1:1]};
    end

    prod = negRes ? -{accHi, accLo} : {accHi, accLo};
    case (opL)
      OpMul:                    mdResult = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: mdResult = prod[2*XLEN-1:XLEN];
      OpDiv:  mdResult = (magB == '0) ? '1 : (negRes ? -accLo : accLo);
      OpDivu: mdResult = (magB == '0) ? '1 : accLo;
      OpRem:  mdResult = (magB == '0) ? rawA : (negRes ? -accHi : accHi);
      OpRemu: mdResult = (magB == '0) ? rawA : accHi;
      default: mdResult = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busyQ  <= 1'b0;
      opL    <= '0;
      negRes <= 1'b0;
      accHi  <= '0;
      accLo  <= '0;
      magB   <= '0;
      rawA   <= '0;
      ctrlL  <= '0;
      storeL <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid && isMdOp) begin
          opL    <= bus.in_AluOp;
          ctrlL  <= inCtrl;
          storeL <= bus.in_store_data;
          rawA   <= bus.in_op1;
          magB   <= isDivIn ? magBIn : magAIn;
          accLo  <= isDivIn ? magAIn : magBIn;
          accHi  <= '0;
          negRes <= (bus.in_AluOp == OpRem) ? signA : (signA ^ signB);
          cnt    <= '0;
          busyQ  <= 1'b1;
          state  <= BUSY;
        end
        BUSY: begin
          accHi <= nextHi;
          accLo <= nextLo;
          cnt   <= cnt + 1'b1;
          if (cnt == LastIter) state <= DONE;
        end
        DONE: begin
          busyQ <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mdDone       = (state == DONE);
  assign stateIdle    = (state == IDLE);
  assign bus.busy     = busyQ;
  assign bus.dbgState = state;
`else
  assign isMdOp       = 1'b0;
  assign mdDone       = 1'b0;
  assign stateIdle    = 1'b1;
  assign ctrlL        = '0;
  assign storeL       = '0;
  assign mdResult     = '0;
  assign bus.busy     = 1'b0;
  assign bus.dbgState = 2'd0;
`endif

  logic [XLEN-1:0] resultQ, storeQ;
  ctrl_t           ctrlQ;

  // Bubbles clear every control field but leave the data registers holding their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resultQ <= '0;
      storeQ  <= '0;
      ctrlQ   <= '0;
    end else if (mdDone) begin
      resultQ <= mdResult;
      storeQ  <= storeL;
      ctrlQ   <= ctrlL;
    end else if (stateIdle && bus.in_valid && !isMdOp) begin
      resultQ <= aluRes;
      storeQ  <= bus.in_store_data;
      ctrlQ   <= inCtrl;
    end else begin
      ctrlQ   <= '0;
    end
  end

  assign bus.out_AluResult    = resultQ;
  assign bus.out_StoreData    = storeQ;
  assign bus.out_MemRead      = ctrlQ.memRead;
  assign bus.out_MemWrite     = ctrlQ.memWrite;
  assign bus.out_MemToReg     = ctrlQ.memToReg;
  assign bus.out_RegWrite     = ctrlQ.regWrite;
  assign bus.out_RegDataSrc   = ctrlQ.regDataSrc;
  assign bus.out_RegDest      = ctrlQ.regDest;
  assign bus.out_PCSrc        = ctrlQ.pcSrc;
  assign bus.out_BranchOffset = ctrlQ.branchOffset;

endmodule
